// File: rtl/led_trail_pwm_pkg.sv
// rtl/led_trail_pwm_pkg.sv - shared LED brightness and PWM constants
package led_trail_pwm_pkg;

  localparam int LEVEL_MAX  = 15;
  localparam int PWM_PERIOD = 15;

  typedef logic [3:0] level_t;

endpackage

// File: rtl/led_trail_pwm_if.sv
// rtl/led_trail_pwm_if.sv - LED pattern in, PWM drive and beat pulse out
interface led_trail_pwm_if;

  logic [7:0] leds_in;
  logic       step_in;
  logic [7:0] leds_out;
  logic       beat_out;

  modport master (output leds_in, output step_in, input leds_out, input beat_out);
  modport slave  (input leds_in, input step_in, output leds_out, output beat_out);

endinterface

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one LED: decaying brightness level and PWM compare
module led_pwm_channel
  import led_trail_pwm_pkg::*;
(
  input  logic   clk_in,
  input  logic   reset,
  input  logic   load,
  input  logic   decay,
  input  level_t pwm_cnt,
  output logic   led
);

  level_t level;

  // A lit LED refreshes to full brightness even on a decay tick.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      if (load) begin
        level <= level_t'(LEVEL_MAX);
      end else if (decay && (level != '0)) begin
        level <= level - 4'd1;
      end
      led <= (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_trail_pwm.sv
// rtl/led_trail_pwm.sv - trailing-fade PWM LED driver with step beat detector
module led_trail_pwm
  import led_trail_pwm_pkg::*;
#(
  parameter int PWM_DIV   = 32,
  parameter int DECAY_DIV = 2000000
) (
  input  logic           clk_in,
  input  logic           reset,
  led_trail_pwm_if.slave bus
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [PW-1:0] pwm_pre;
  logic [DW-1:0] dec_pre;
  level_t        pwm_cnt;
  logic          pwm_wrap;
  logic          decay_tick;
  logic          step_s1;
  logic          step_s2;
  logic          step_edge;
  logic [2:0]    primed;
  logic [7:0]    leds_q;

  assign pwm_wrap   = (pwm_pre == PW'(PWM_DIV - 1));
  assign decay_tick = (dec_pre == DW'(DECAY_DIV - 1));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pwm_pre <= '0;
      dec_pre <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_pre <= pwm_wrap ? '0 : pwm_pre + PW'(1);
      dec_pre <= decay_tick ? '0 : dec_pre + DW'(1);
      if (pwm_wrap) begin
        pwm_cnt <= (pwm_cnt == level_t'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + 4'd1;
      end
    end
  end

  // primed marks when the edge flop holds a real sample, so a step_in that
  // was already high across reset is not mistaken for a fresh rising edge.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      step_s1      <= 1'b0;
      step_s2      <= 1'b0;
      step_edge    <= 1'b0;
      primed       <= '0;
      bus.beat_out <= 1'b0;
    end else begin
      step_s1      <= bus.step_in;
      step_s2      <= step_s1;
      step_edge    <= step_s2;
      primed       <= {primed[1:0], 1'b1};
      bus.beat_out <= step_s2 & ~step_edge & primed[2];
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_ch
    led_pwm_channel u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .load    (bus.leds_in[i]),
      .decay   (decay_tick),
      .pwm_cnt (pwm_cnt),
      .led     (leds_q[i])
    );
  end

  assign bus.leds_out = leds_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// tb/tb_led_trail_pwm.sv - scoreboard bench for led_trail_pwm
module tb_led_trail_pwm;

  typedef struct {
    string      nm;
    logic [7:0] mask;
    logic [7:0] leds;
    logic [7:0] mask2;
    logic [7:0] leds2;
    logic       chk_beat;
    logic       beat;
    logic       cnt_clr;
    int         cnt_exp;
  } exp_t;

  logic clk_in;
  logic reset;
  int   n_pass;
  int   n_total;
  int   hi_cnt;
  exp_t sb[$];

  led_trail_pwm_if bus ();
  led_trail_pwm_if bus2 ();

  led_trail_pwm #(.PWM_DIV(2), .DECAY_DIV(4)) u_dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  // Slow-decay copy so a mid-range level stays put for whole PWM periods.
  led_trail_pwm #(.PWM_DIV(2), .DECAY_DIV(64)) u_dut2 (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus2)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic exp_t blank(input string nm);
    exp_t x;
    x.nm       = nm;
    x.mask     = '0;
    x.leds     = '0;
    x.mask2    = '0;
    x.leds2    = '0;
    x.chk_beat = 1'b0;
    x.beat     = 1'b0;
    x.cnt_clr  = 1'b0;
    x.cnt_exp  = -1;
    return x;
  endfunction

  // Channel-0 level during cycle m after a single load in cycle 0.
  function automatic int lvl_b(input int m);
    if (m == 0 || m >= 60) return 0;
    return 15 - m / 4;
  endfunction

  task automatic tick(input logic rst, input logic [7:0] li, input logic st,
                      input logic [7:0] li2, input exp_t ex);
    @(posedge clk_in);
    #1;
    reset         = rst;
    bus.leds_in   = li;
    bus.step_in   = st;
    bus2.leds_in  = li2;
    bus2.step_in  = 1'b0;
    sb.push_back(ex);
  endtask

  initial begin
    exp_t cur;
    forever begin
      @(negedge clk_in);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        if (cur.mask != 8'h00) begin
          n_total++;
          if ((bus.leds_out & cur.mask) !== (cur.leds & cur.mask))
            $display("FAIL %s: leds_out=%h required %h (mask %h) at %0t",
                     cur.nm, bus.leds_out, cur.leds, cur.mask, $time);
          else n_pass++;
        end
        if (cur.chk_beat) begin
          n_total++;
          if (bus.beat_out !== cur.beat)
            $display("FAIL %s: beat_out=%b required %b at %0t",
                     cur.nm, bus.beat_out, cur.beat, $time);
          else n_pass++;
        end
        if (cur.cnt_clr) hi_cnt = 0;
        if (cur.mask2 != 8'h00) begin
          n_total++;
          if ((bus2.leds_out & cur.mask2) !== (cur.leds2 & cur.mask2))
            $display("FAIL %s: leds_out=%h required %h (mask %h) at %0t",
                     cur.nm, bus2.leds_out, cur.leds2, cur.mask2, $time);
          else n_pass++;
          if (bus2.leds_out[3] === 1'b1) hi_cnt++;
        end
        if (cur.cnt_exp >= 0) begin
          n_total++;
          if (hi_cnt != cur.cnt_exp)
            $display("FAIL %s: high cycles=%0d required %0d", cur.nm, hi_cnt, cur.cnt_exp);
          else n_pass++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks done", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    exp_t x;
    n_pass  = 0;
    n_total = 0;
    hi_cnt  = 0;
    reset        = 1'b1;
    bus.leds_in  = '0;
    bus.step_in  = 1'b1;
    bus2.leds_in = '0;
    bus2.step_in = 1'b0;

    // Reset with step_in held high: quiet during and after release.
    tick(1'b1, 8'h00, 1'b1, 8'h00, blank("a_pre"));
    for (int n = 0; n < 2; n++) begin
      x = blank("reset_state");
      x.mask = 8'hFF; x.leds = 8'h00; x.chk_beat = 1'b1; x.beat = 1'b0;
      tick(1'b1, 8'h00, 1'b1, 8'h00, x);
    end
    for (int n = 0; n < 10; n++) begin
      x = blank("step_high_release");
      x.mask = 8'hFF; x.leds = 8'h00; x.chk_beat = 1'b1; x.beat = 1'b0;
      tick(1'b0, 8'h00, 1'b1, 8'h00, x);
    end

    // Single load on channel 0 decays one step per 4 cycles and holds at 0.
    tick(1'b1, 8'h00, 1'b0, 8'h00, blank("b_rst"));
    for (int n = 0; n < 76; n++) begin
      x = blank("decay_ch0");
      if (n >= 1) begin
        x.mask = 8'h01;
        x.leds = {7'd0, (lvl_b(n - 1) > (((n - 1) / 2) % 15))};
        x.chk_beat = 1'b1; x.beat = 1'b0;
      end
      tick(1'b0, (n == 0) ? 8'h01 : 8'h00, 1'b0, 8'h00, x);
    end

    // Channel 3 held at 15; slow copy decays to level 5 and is measured.
    tick(1'b1, 8'h00, 1'b0, 8'h00, blank("c_rst"));
    for (int n = 0; n < 693; n++) begin
      x = blank("full_on_ch3");
      if (n >= 2) begin
        x.mask = 8'h08; x.leds = 8'h08;
      end
      if (n >= 661 && n <= 690) begin
        x.nm = "duty_level5";
        x.mask2 = 8'h08;
        x.leds2 = {4'd0, ((((n - 1) / 2) % 15) < 5), 3'd0};
        x.cnt_clr = (n == 661);
        x.cnt_exp = (n == 690) ? 10 : -1;
      end
      tick(1'b0, 8'h08, 1'b0, (n == 0) ? 8'h08 : 8'h00, x);
    end

    // step_in rises in cycle 5: one beat in cycle 8, none while held high.
    tick(1'b1, 8'h00, 1'b0, 8'h00, blank("d_rst"));
    for (int n = 0; n < 31; n++) begin
      x = blank("beat_pulse");
      x.chk_beat = 1'b1; x.beat = (n == 8);
      x.mask = 8'hFF; x.leds = 8'h00;
      tick(1'b0, 8'h00, (n >= 5), 8'h00, x);
    end

    // Non-one-hot load, then a load landing on a decay tick (cycle 27).
    tick(1'b1, 8'h00, 1'b0, 8'h00, blank("e_rst"));
    for (int n = 0; n < 41; n++) begin
      x = blank("multi_load");
      if (n >= 1 && n <= 8) begin
        x.mask = 8'hFF; x.leds = (n == 1) ? 8'h00 : 8'hC3;
      end else if (n >= 9 && n <= 28) begin
        x.nm = "load_on_tick"; x.mask = 8'h24; x.leds = 8'h00;
      end else if (n >= 29 && n <= 36) begin
        x.nm = "load_on_tick"; x.mask = 8'h24; x.leds = 8'h24;
      end
      tick(1'b0, (n == 0) ? 8'hC3 : ((n == 27) ? 8'h24 : 8'h00), 1'b0, 8'h00, x);
    end

    // Reset mid-decay while loading; decay phase restarts from zero.
    tick(1'b1, 8'h00, 1'b0, 8'h00, blank("g_rst"));
    for (int n = 0; n < 6; n++) tick(1'b0, 8'hFF, 1'b0, 8'h00, blank("g_load"));
    tick(1'b1, 8'hFF, 1'b0, 8'h00, blank("g_mid_rst"));
    for (int n = 0; n < 35; n++) begin
      x = blank("reset_mid_decay");
      x.mask = 8'hFF;
      if (n == 0) begin
        x.leds = 8'h00; x.chk_beat = 1'b1; x.beat = 1'b0;
      end else if (n == 1 || n == 29 || n == 30) begin
        x.nm = "decay_restart"; x.leds = 8'h00;
      end else begin
        x.nm = "decay_restart"; x.leds = 8'h10;
      end
      tick(1'b0, (n <= 26) ? 8'h10 : 8'h00, 1'b0, 8'h00, x);
    end

    repeat (3) @(negedge clk_in);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_trail_pwm.md
LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

Interface
REQ-001 SHALL have parameter PWM_DIV, default 32: clk_in cycles per PWM count step, legal range 1..255.
REQ-002 SHALL have parameter DECAY_DIV, default 2000000: clk_in cycles per brightness decay step, legal range 1..2^24-1.
REQ-003 SHALL have port clk_in  input  1: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port leds_in  input  8: one-hot LED pattern from the clock divider, in the clk_in domain.
REQ-006 SHALL have port step_in  input  1: the divider's slow square wave (clk_out), treated as asynchronous.
REQ-007 SHALL have port leds_out  output  8: PWM-modulated LED drive, registered.
REQ-008 SHALL have port beat_out  output  1: one-cycle pulse on each step_in rising edge.

Function
REQ-009 SHALL keep one 4-bit brightness level per channel (0 = off, 15 = full).
REQ-010 SHALL load level[i] with 15 on any cycle where leds_in[i]=1. This takes priority over decay in the same cycle.
REQ-011 SHALL have a decay prescaler that counts 0..DECAY_DIV-1 and wraps. Wrap cycle = decay tick.
REQ-012 On a decay tick, SHALL decrement every level[i] with leds_in[i]=0 by 1, saturating at 0 (no wrap to 15).
REQ-013 SHALL have a PWM prescaler that counts 0..PWM_DIV-1. On its wrap, SHALL advance pwm_cnt.
REQ-014 SHALL count pwm_cnt 0..14 and wrap 14->0, giving a PWM period of 15*PWM_DIV cycles.
REQ-015 SHALL set leds_out[i] <= (level[i] > pwm_cnt) each cycle, one cycle after the level and pwm_cnt values it uses. Level 15 is therefore always on and level 0 always off.
REQ-016 Duty of level L SHALL be exactly L/15 over one PWM period when L is stable.
REQ-017 SHALL pass step_in through a 2-flop synchronizer, then a third edge-detect flop.
REQ-018 SHALL assert beat_out for exactly one cycle when the edge-detect flop is 0 and the synchronized value is 1. Latency is 3 clk_in edges from a step_in rise.
REQ-019 leds_in values that are not one-hot SHALL be handled per channel: every set bit loads 15 independently.
REQ-020 If a decay tick and a PWM wrap coincide, both SHALL take effect in that cycle.

Reset
REQ-021 On reset=1 at a clk_in rising edge, SHALL clear all levels, both prescalers, pwm_cnt, the synchronizer and edge flops, leds_out (8'h00) and beat_out (0).
REQ-022 Reset SHALL override leds_in loading in the same cycle.
REQ-023 A reset mid-decay or mid-PWM-period SHALL restart both prescalers from 0 on the first cycle after reset deasserts.
REQ-024 A step_in level already high at reset release SHALL NOT produce a beat_out pulse until a new rising edge occurs.

Structure
REQ-025 SHALL place LEVEL_MAX=15 and PWM_PERIOD=15 in the shared LED constants package/header.
REQ-026 SHALL implement each channel in sub-module led_pwm_channel (level register plus compare), instantiated 8 times.
REQ-027 SHALL size the prescalers with clog2 of their parameter. There SHALL be no other clock domains and no latches.

Verification (PWM_DIV=2, DECAY_DIV=4 unless stated)
REQ-028 Reset with step_in held at 1 -> leds_out=8'h00, beat_out=0 throughout reset and after release.
REQ-029 leds_in=8'h01 for 1 cycle, then 8'h00 -> channel 0 level goes 15,14,...,0, one step per 4 cycles, and holds at 0.
REQ-030 Channel 3 held at level 15 -> leds_out[3]=1 every cycle. Level forced to 5 -> exactly 10 high cycles per 30-cycle period.
REQ-031 step_in raised asynchronously -> exactly one beat_out pulse 3 cycles later. Holding step_in high produces no further pulses.
REQ-032 leds_in[2]=1 on a decay-tick cycle -> level[2]=15, not 14.
REQ-033 reset asserted mid-decay -> all outputs 0 next cycle. Decay restarts with a full 4-cycle interval after release.
